// File: rtl/fmn_axi_single_master_if.sv
// fmn_axi_single_master_if: command/response stream plus one single-beat AXI4 master port
interface fmn_axi_single_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LAT_WIDTH  = 16
);
  logic                    cmd_valid, cmd_ready, cmd_write;
  logic [ADDR_WIDTH-1:0]   cmd_addr;
  logic [DATA_WIDTH-1:0]   cmd_wdata;
  logic [DATA_WIDTH/8-1:0] cmd_wstrb;
  logic                    rsp_valid, rsp_ready, rsp_is_read;
  logic [DATA_WIDTH-1:0]   rsp_rdata;
  logic [1:0]              rsp_resp;
  logic [LAT_WIDTH-1:0]    rsp_latency;
  logic                    M_awid, M_awvalid, M_awready;
  logic [ADDR_WIDTH-1:0]   M_awaddr;
  logic [7:0]              M_awlen;
  logic [2:0]              M_awsize, M_awprot;
  logic [1:0]              M_awburst;
  logic [3:0]              M_awcache;
  logic [DATA_WIDTH-1:0]   M_wdata;
  logic [DATA_WIDTH/8-1:0] M_wstrb;
  logic                    M_wlast, M_wvalid, M_wready;
  logic                    M_bid, M_bvalid, M_bready;
  logic [1:0]              M_bresp;
  logic                    M_arid, M_arvalid, M_arready;
  logic [ADDR_WIDTH-1:0]   M_araddr;
  logic [7:0]              M_arlen;
  logic [2:0]              M_arsize, M_arprot;
  logic [1:0]              M_arburst;
  logic [3:0]              M_arcache;
  logic                    M_rid, M_rlast, M_rvalid, M_rready;
  logic [DATA_WIDTH-1:0]   M_rdata;
  logic [1:0]              M_rresp;
  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
    input  M_awready, M_wready, M_bid, M_bresp, M_bvalid, M_arready,
    input  M_rid, M_rdata, M_rresp, M_rlast, M_rvalid,
    output cmd_ready, rsp_valid, rsp_is_read, rsp_rdata, rsp_resp, rsp_latency,
    output M_awid, M_awaddr, M_awlen, M_awsize, M_awburst, M_awprot, M_awcache, M_awvalid,
    output M_wdata, M_wstrb, M_wlast, M_wvalid, M_bready,
    output M_arid, M_araddr, M_arlen, M_arsize, M_arburst, M_arprot, M_arcache, M_arvalid,
    output M_rready
  );
  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
    output M_awready, M_wready, M_bid, M_bresp, M_bvalid, M_arready,
    output M_rid, M_rdata, M_rresp, M_rlast, M_rvalid,
    input  cmd_ready, rsp_valid, rsp_is_read, rsp_rdata, rsp_resp, rsp_latency,
    input  M_awid, M_awaddr, M_awlen, M_awsize, M_awburst, M_awprot, M_awcache, M_awvalid,
    input  M_wdata, M_wstrb, M_wlast, M_wvalid, M_bready,
    input  M_arid, M_araddr, M_arlen, M_arsize, M_arburst, M_arprot, M_arcache, M_arvalid,
    input  M_rready
  );
endinterface

// File: rtl/fmn_axi_single_master.sv
// fmn_axi_single_master: one-outstanding command stream to single-beat AXI4 master with latency measurement
module fmn_axi_single_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter bit ID_VALUE   = 1'b0,
  parameter int LAT_WIDTH  = 16
) (
  input logic                    aclk,
  input logic                    aresetn,
  fmn_axi_single_master_if.master bus
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] WADDR = 3'd1;
  localparam logic [2:0] WRESP = 3'd2;
  localparam logic [2:0] RADDR = 3'd3;
  localparam logic [2:0] RDATA = 3'd4;
  localparam logic [2:0] RESP  = 3'd5;
  localparam logic [2:0] SIZE  = 3'($clog2(DATA_WIDTH/8));
  logic [2:0]              state;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH/8-1:0] wstrb_q;
  logic [LAT_WIDTH-1:0]    lat, lat_nxt;
  logic                    unused_ok;
  assign unused_ok     = ^{bus.M_bid, bus.M_rid, bus.M_rlast};
  assign bus.cmd_ready = aresetn && state == IDLE;
  assign lat_nxt       = &lat ? lat : lat + 1'b1;
  assign bus.M_awid    = ID_VALUE;
  assign bus.M_awaddr  = addr_q;
  assign bus.M_awlen   = 8'd0;
  assign bus.M_awsize  = SIZE;
  assign bus.M_awburst = 2'b01;
  assign bus.M_awprot  = 3'd0;
  assign bus.M_awcache = 4'b0011;
  assign bus.M_wdata   = wdata_q;
  assign bus.M_wstrb   = wstrb_q;
  assign bus.M_wlast   = 1'b1;
  assign bus.M_arid    = ID_VALUE;
  assign bus.M_araddr  = addr_q;
  assign bus.M_arlen   = 8'd0;
  assign bus.M_arsize  = SIZE;
  assign bus.M_arburst = 2'b01;
  assign bus.M_arprot  = 3'd0;
  assign bus.M_arcache = 4'b0011;
  // Sequence one transaction; lat reads 1 in the cycle after accept, so the value latched
  // at the B/R handshake counts every cycle from accept through the handshake cycle.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state           <= IDLE;
      addr_q          <= '0;
      wdata_q         <= '0;
      wstrb_q         <= '0;
      lat             <= '0;
      bus.M_awvalid   <= 1'b0;
      bus.M_wvalid    <= 1'b0;
      bus.M_arvalid   <= 1'b0;
      bus.M_bready    <= 1'b0;
      bus.M_rready    <= 1'b0;
      bus.rsp_valid   <= 1'b0;
      bus.rsp_is_read <= 1'b0;
      bus.rsp_rdata   <= '0;
      bus.rsp_resp    <= 2'd0;
      bus.rsp_latency <= '0;
    end else begin
      lat <= lat_nxt;
      case (state)
        IDLE: if (bus.cmd_valid) begin
          addr_q        <= bus.cmd_addr;
          wdata_q       <= bus.cmd_wdata;
          wstrb_q       <= bus.cmd_wstrb;
          lat           <= LAT_WIDTH'(1);
          bus.M_awvalid <= bus.cmd_write;
          bus.M_wvalid  <= bus.cmd_write;
          bus.M_arvalid <= !bus.cmd_write;
          state         <= bus.cmd_write ? WADDR : RADDR;
        end
        WADDR: begin
          if (bus.M_awready) bus.M_awvalid <= 1'b0;
          if (bus.M_wready) bus.M_wvalid <= 1'b0;
          if ((!bus.M_awvalid || bus.M_awready) && (!bus.M_wvalid || bus.M_wready)) begin
            bus.M_bready <= 1'b1;
            state        <= WRESP;
          end
        end
        WRESP: if (bus.M_bvalid) begin
          bus.M_bready    <= 1'b0;
          bus.rsp_valid   <= 1'b1;
          bus.rsp_is_read <= 1'b0;
          bus.rsp_rdata   <= '0;
          bus.rsp_resp    <= bus.M_bresp;
          bus.rsp_latency <= lat_nxt;
          state           <= RESP;
        end
        RADDR: if (bus.M_arready) begin
          bus.M_arvalid <= 1'b0;
          bus.M_rready  <= 1'b1;
          state         <= RDATA;
        end
        RDATA: if (bus.M_rvalid) begin
          bus.M_rready    <= 1'b0;
          bus.rsp_valid   <= 1'b1;
          bus.rsp_is_read <= 1'b1;
          bus.rsp_rdata   <= bus.M_rdata;
          bus.rsp_resp    <= bus.M_rresp;
          bus.rsp_latency <= lat_nxt;
          state           <= RESP;
        end
        RESP: if (bus.rsp_ready) begin
          bus.rsp_valid <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fmn_axi_single_master.sv
// tb_fmn_axi_single_master: table vectors, random transactions and reset/saturation sequences
module tb_fmn_axi_single_master;
  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  int   total = 0;
  int   bad = 0;
  always #5 aclk = ~aclk;
  fmn_axi_single_master_if bus ();
  fmn_axi_single_master_if #(.LAT_WIDTH(4)) b5 ();
  fmn_axi_single_master dut (.aclk(aclk), .aresetn(aresetn), .bus(bus.master));
  fmn_axi_single_master #(.LAT_WIDTH(4)) u5 (.aclk(aclk), .aresetn(aresetn), .bus(b5.master));
  typedef struct {
    logic        wr;
    logic [31:0] addr, wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic [1:0]  resp;
    int          aw_dly, w_dly, b_dly, ar_dly, r_dly, rsp_dly;
    logic        exp_is_read;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
    int          exp_lat;
  } vec_t;
  vec_t vecs[6];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask
  task automatic idle_slave();
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    bus.M_awready = 1'b0;
    bus.M_wready  = 1'b0;
    bus.M_arready = 1'b0;
    bus.M_bvalid  = 1'b0;
    bus.M_rvalid  = 1'b0;
  endtask
  // Issue one command and act as an AXI slave with the vector's delays; exp_lat < 0 means
  // the latency is taken from the observed accept and B/R handshake cycles.
  task automatic run_txn(input vec_t v);
    int awc = 0, wc = 0, arc = 0, bc = 0, rc = 0, rspc = 0, perr = 0, hs = 0;
    int aw_n = 0, w_n = 0, ar_n = 0, wt = 0, exp_lat;
    logic aw_d = 1'b0, w_d = 1'b0, ar_d = 1'b0, x_d = 1'b0, done = 1'b0;
    logic        p_isr = 1'b0;
    logic [31:0] p_rdata = '0;
    logic [1:0]  p_resp = '0;
    logic [15:0] p_lat = '0;
    idle_slave();
    bus.cmd_write = v.wr;
    bus.cmd_addr  = v.addr;
    bus.cmd_wdata = v.wdata;
    bus.cmd_wstrb = v.wstrb;
    bus.cmd_valid = 1'b1;
    #1;
    while (!bus.cmd_ready && wt < 20) begin
      @(negedge aclk);
      #1;
      wt++;
    end
    chk("accept", 64'(bus.cmd_ready), 64'(1));
    if (!bus.cmd_ready) begin
      idle_slave();
      return;
    end
    @(negedge aclk);
    for (int c = 1; c < 200 && !done; c++) begin
      bus.cmd_valid = 1'($urandom_range(0, 1));
      bus.cmd_addr  = $urandom;
      if (bus.cmd_ready) perr++;
      if (v.wr && (bus.M_arvalid || bus.M_awvalid == aw_d || bus.M_wvalid == w_d)) perr++;
      if (!v.wr && (bus.M_awvalid || bus.M_wvalid || bus.M_arvalid == ar_d)) perr++;
      if (bus.M_bready != (v.wr && aw_d && w_d && !x_d)) perr++;
      if (bus.M_rready != (!v.wr && ar_d && !x_d)) perr++;
      if (bus.rsp_valid != x_d) perr++;
      bus.M_awready = bus.M_awvalid && awc >= v.aw_dly;
      bus.M_wready  = bus.M_wvalid && wc >= v.w_dly;
      bus.M_arready = bus.M_arvalid && arc >= v.ar_dly;
      bus.M_bvalid  = v.wr && aw_d && w_d && !x_d && bc >= v.b_dly;
      bus.M_rvalid  = !v.wr && ar_d && !x_d && rc >= v.r_dly;
      bus.M_bresp   = v.resp;
      bus.M_rresp   = v.resp;
      bus.M_rdata   = v.rdata;
      bus.M_rlast   = 1'b1;
      bus.M_bid     = 1'($urandom_range(0, 1));
      bus.M_rid     = 1'($urandom_range(0, 1));
      if (bus.M_awready) begin
        aw_n++;
        chk("aw_fields", 64'({bus.M_awaddr, bus.M_awlen, bus.M_awsize, bus.M_awburst, bus.M_awprot, bus.M_awcache, bus.M_awid}),
            64'({v.addr, 8'd0, 3'd2, 2'b01, 3'd0, 4'b0011, 1'b0}));
      end
      if (bus.M_wready) begin
        w_n++;
        chk("w_fields", 64'({bus.M_wdata, bus.M_wstrb, bus.M_wlast}), 64'({v.wdata, v.wstrb, 1'b1}));
      end
      if (bus.M_arready) begin
        ar_n++;
        chk("ar_fields", 64'({bus.M_araddr, bus.M_arlen, bus.M_arsize, bus.M_arburst, bus.M_arprot, bus.M_arcache, bus.M_arid}),
            64'({v.addr, 8'd0, 3'd2, 2'b01, 3'd0, 4'b0011, 1'b0}));
      end
      if (x_d) begin
        if (rspc == 0) begin
          p_isr = bus.rsp_is_read;
          p_rdata = bus.rsp_rdata;
          p_resp = bus.rsp_resp;
          p_lat = bus.rsp_latency;
        end else if ({bus.rsp_is_read, bus.rsp_rdata, bus.rsp_resp, bus.rsp_latency} != {p_isr, p_rdata, p_resp, p_lat}) perr++;
        bus.rsp_ready = rspc >= v.rsp_dly;
        if (bus.rsp_ready && bus.rsp_valid) done = 1'b1;
        rspc++;
      end
      if ((bus.M_bvalid && bus.M_bready) || (bus.M_rvalid && bus.M_rready)) begin
        hs = c;
        x_d = 1'b1;
      end
      if (bus.M_awvalid) awc++;
      if (bus.M_wvalid) wc++;
      if (bus.M_arvalid) arc++;
      if (aw_d && w_d) bc++;
      if (ar_d) rc++;
      if (bus.M_awready) aw_d = 1'b1;
      if (bus.M_wready) w_d = 1'b1;
      if (bus.M_arready) ar_d = 1'b1;
      @(negedge aclk);
    end
    idle_slave();
    chk("completed", 64'(done), 64'(1));
    if (v.wr) begin
      chk("aw_beats", 64'(aw_n), 64'(1));
      chk("w_beats", 64'(w_n), 64'(1));
    end else chk("ar_beats", 64'(ar_n), 64'(1));
    chk("protocol", 64'(perr), 64'(0));
    exp_lat = v.exp_lat >= 0 ? v.exp_lat : (hs + 1 > 65535 ? 65535 : hs + 1);
    if (done) begin
      chk("rsp_payload", 64'({p_isr, p_rdata, p_resp}), 64'({v.exp_is_read, v.exp_rdata, v.exp_resp}));
      chk("rsp_latency", 64'(p_lat), 64'(exp_lat));
    end
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    vec_t v;
    logic ok;
    vecs[0] = '{1'b1, 32'h40,  32'hDEADBEEF, 4'hF, 32'h0,        2'd0, 0, 0, 0, 0, 0, 0,  1'b0, 32'h0,        2'd0, 3};
    vecs[1] = '{1'b1, 32'h44,  32'hCAFEF00D, 4'h3, 32'h0,        2'd0, 0, 4, 1, 0, 0, 0,  1'b0, 32'h0,        2'd0, 8};
    vecs[2] = '{1'b0, 32'h80,  32'h0,        4'h0, 32'h12345678, 2'd2, 0, 0, 0, 2, 5, 0,  1'b1, 32'h12345678, 2'd2, 10};
    vecs[3] = '{1'b1, 32'h100, 32'h11223344, 4'hC, 32'h0,        2'd1, 3, 0, 0, 0, 0, 10, 1'b0, 32'h0,        2'd1, 6};
    vecs[4] = '{1'b0, 32'h200, 32'h0,        4'h0, 32'hA5A5A5A5, 2'd3, 0, 0, 0, 0, 0, 10, 1'b1, 32'hA5A5A5A5, 2'd3, 3};
    vecs[5] = '{1'b1, 32'h204, 32'h0,        4'h0, 32'h0,        2'd2, 2, 2, 2, 0, 0, 0,  1'b0, 32'h0,        2'd2, 7};
    idle_slave();
    {bus.cmd_write, bus.cmd_addr, bus.cmd_wdata, bus.cmd_wstrb} = '0;
    {bus.M_bid, bus.M_bresp, bus.M_rid, bus.M_rdata, bus.M_rresp, bus.M_rlast} = '0;
    {b5.cmd_valid, b5.cmd_write, b5.cmd_addr, b5.cmd_wdata, b5.cmd_wstrb, b5.rsp_ready} = '0;
    {b5.M_awready, b5.M_wready, b5.M_bid, b5.M_bresp, b5.M_bvalid, b5.M_arready} = '0;
    {b5.M_rid, b5.M_rdata, b5.M_rresp, b5.M_rlast, b5.M_rvalid} = '0;
    repeat (3) @(negedge aclk);
    chk("rst_ctrl", 64'({bus.cmd_ready, bus.M_awvalid, bus.M_wvalid, bus.M_arvalid, bus.M_bready, bus.M_rready, bus.rsp_valid}), 64'(0));
    chk("rst_payload", 64'({bus.rsp_is_read, bus.rsp_rdata, bus.rsp_resp, bus.rsp_latency}), 64'(0));
    aresetn = 1'b1;
    #1 chk("rst_release_ready", 64'(bus.cmd_ready), 64'(1));
    foreach (vecs[i]) run_txn(vecs[i]);
    for (int n = 0; n < 40; n++) begin
      v.wr = 1'($urandom_range(0, 1));
      v.addr = {$urandom_range(0, 65535), 16'h0} | 32'($urandom_range(0, 255) * 4);
      v.wdata = $urandom;
      v.wstrb = 4'($urandom_range(0, 15));
      v.rdata = $urandom;
      v.resp = 2'($urandom_range(0, 3));
      v.aw_dly = $urandom_range(0, 4);
      v.w_dly = $urandom_range(0, 4);
      v.b_dly = $urandom_range(0, 4);
      v.ar_dly = $urandom_range(0, 4);
      v.r_dly = $urandom_range(0, 4);
      v.rsp_dly = $urandom_range(0, 3);
      v.exp_is_read = !v.wr;
      v.exp_rdata = v.wr ? 32'h0 : v.rdata;
      v.exp_resp = v.resp;
      v.exp_lat = -1;
      run_txn(v);
    end
    b5.cmd_write = 1'b1;
    b5.cmd_addr = 32'h10;
    b5.cmd_wdata = 32'h5A5A5A5A;
    b5.cmd_wstrb = 4'hF;
    b5.cmd_valid = 1'b1;
    b5.M_awready = 1'b1;
    b5.M_wready = 1'b1;
    #1 chk("sat_accept", 64'(b5.cmd_ready), 64'(1));
    @(negedge aclk);
    b5.cmd_valid = 1'b0;
    repeat (39) @(negedge aclk);
    b5.M_bvalid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 5 && !ok; k++) begin
      @(negedge aclk);
      b5.M_bvalid = 1'b0;
      ok = b5.rsp_valid;
    end
    chk("sat_rsp_valid", 64'(b5.rsp_valid), 64'(1));
    chk("sat_latency", 64'(b5.rsp_latency), 64'(15));
    b5.rsp_ready = 1'b1;
    @(negedge aclk);
    b5.rsp_ready = 1'b0;
    idle_slave();
    bus.cmd_write = 1'b1;
    bus.cmd_addr = 32'h300;
    bus.cmd_valid = 1'b1;
    #1 chk("rst6_accept", 64'(bus.cmd_ready), 64'(1));
    @(negedge aclk);
    bus.cmd_valid = 1'b0;
    chk("rst6_waddr_valids", 64'({bus.M_awvalid, bus.M_wvalid}), 64'(2'b11));
    aresetn = 1'b0;
    #1 chk("rst6_ready_low", 64'(bus.cmd_ready), 64'(0));
    @(negedge aclk);
    chk("rst6_cleared", 64'({bus.M_awvalid, bus.M_wvalid, bus.M_arvalid, bus.M_bready, bus.M_rready, bus.rsp_valid, bus.cmd_ready}), 64'(0));
    aresetn = 1'b1;
    #1 chk("rst6_ready_high", 64'(bus.cmd_ready), 64'(1));
    run_txn(vecs[0]);
    run_txn(vecs[2]);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
